// File: rtl/univ_shift_reg_param.sv
// Universal shift register: hold, logical shift left/right, parallel load,
// rotate left/right, arithmetic shift right and clear, with a saturating
// count of loaded bits that have not yet been shifted out.
module univ_shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             right_s_in,
  input  logic             left_s_in,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             s_left,
  output logic             s_right,
  output logic [CNT_W-1:0] bits_left,
  output logic             empty
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  localparam logic [AMT_W:0]   WIDTH_A = (AMT_W + 1)'(WIDTH);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = '1;

  // Saturating subtract: the remaining-bit count bottoms out at zero.
  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Effective distance; out-of-range amt (non power-of-2 widths) clamps to WIDTH-1.
  logic [AMT_W-1:0] k;
  if ((1 << AMT_W) == WIDTH) begin : g_pow2
    assign k = amt;
  end else begin : g_clamp
    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH - 1);
    assign k = (amt > MAX_AMT) ? MAX_AMT : amt;
  end

  // Complementary distance for the wrap-around half of a rotate; k = 0 gives
  // a shift by WIDTH, which contributes nothing.
  logic [AMT_W:0] k_inv;
  assign k_inv = WIDTH_A - {1'b0, k};

  logic signed [WIDTH-1:0] pout_s;
  logic        [WIDTH-1:0] shr_val;
  logic        [WIDTH-1:0] shl_val;
  logic        [WIDTH-1:0] ror_val;
  logic        [WIDTH-1:0] rol_val;
  logic        [WIDTH-1:0] asr_val;

  assign pout_s  = $signed(pout);
  assign shr_val = (pout >> k) | (right_s_in ? ~(ONES >> k) : '0);
  assign shl_val = (pout << k) | (left_s_in  ? ~(ONES << k) : '0);
  assign ror_val = (pout >> k) | (pout << k_inv);
  assign rol_val = (pout << k) | (pout >> k_inv);
  assign asr_val = $unsigned(pout_s >>> k);

  logic [WIDTH-1:0] pout_nx;
  logic [CNT_W-1:0] bits_nx;

  // Next-state selection for register contents and remaining-bit count.
  always_comb begin
    pout_nx = pout;
    bits_nx = bits_left;
    case (mode)
      MODE_HOLD: ;
      MODE_SHR: begin
        pout_nx = shr_val;
        bits_nx = sat_sub(bits_left, CNT_W'(k));
      end
      MODE_SHL: begin
        pout_nx = shl_val;
        bits_nx = sat_sub(bits_left, CNT_W'(k));
      end
      MODE_LOAD: begin
        pout_nx = pin;
        bits_nx = FULL;
      end
      MODE_ROR: pout_nx = ror_val;
      MODE_ROL: pout_nx = rol_val;
      MODE_ASR: begin
        pout_nx = asr_val;
        bits_nx = sat_sub(bits_left, CNT_W'(k));
      end
      MODE_CLR: begin
        pout_nx = '0;
        bits_nx = '0;
      end
    endcase
  end

  // Register stage: reset clears everything, enable gates each operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pout      <= '0;
      bits_left <= '0;
    end else if (en) begin
      pout      <= pout_nx;
      bits_left <= bits_nx;
    end
  end

  assign s_left  = pout[0];
  assign s_right = pout[WIDTH-1];
  assign empty   = (bits_left == '0);

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Testbench for univ_shift_reg_param at WIDTH = 8: vector table plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_univ_shift_reg_param;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic             right_s_in;
  logic             left_s_in;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             s_left;
  logic             s_right;
  logic [CNT_W-1:0] bits_left;
  logic             empty;

  always #5 clk = ~clk;

  univ_shift_reg_param #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .amt       (amt),
    .right_s_in(right_s_in),
    .left_s_in (left_s_in),
    .pin       (pin),
    .pout      (pout),
    .s_left    (s_left),
    .s_right   (s_right),
    .bits_left (bits_left),
    .empty     (empty)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [2:0] amt;
    logic       rsin;
    logic       lsin;
    logic [7:0] pin;
    logic [7:0] exp_pout;
    logic [3:0] exp_bits;
  } vec_t;

  typedef struct {
    logic [7:0] pout;
    logic [3:0] bits;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                              input logic [2:0] a, input logic rs, input logic ls,
                              input logic [7:0] p, input logic [7:0] ep,
                              input logic [3:0] eb);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.amt = a; v.rsin = rs; v.lsin = ls;
    v.pin = p; v.exp_pout = ep; v.exp_bits = eb;
    return v;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, req);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    reset      = v.rst_n;
    en         = v.en;
    mode       = v.mode;
    amt        = v.amt;
    right_s_in = v.rsin;
    left_s_in  = v.lsin;
    pin        = v.pin;
    sb.push_back('{pout: v.exp_pout, bits: v.exp_bits, id: id});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: got no expectation, expected one", id);
    end else begin
      e = sb.pop_front();
      check("pout",      e.id, pout,                   e.pout);
      check("bits_left", e.id, {4'h0, bits_left},      {4'h0, e.bits});
      check("s_left",    e.id, {7'h0, s_left},         {7'h0, e.pout[0]});
      check("s_right",   e.id, {7'h0, s_right},        {7'h0, e.pout[7]});
      check("empty",     e.id, {7'h0, empty},          {7'h0, (e.bits == 4'd0)});
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'd0; amt = 3'd0;
    right_s_in = 1'b0; left_s_in = 1'b0; pin = 8'h00;

    //             rst  en  mode  amt  rsin lsin pin     pout   bits
    vecs.push_back(mk(0, 1, 3'd3, 3'd0, 0, 0, 8'hFF, 8'h00, 4'd0)); // reset wins over load
    vecs.push_back(mk(0, 1, 3'd3, 3'd0, 0, 0, 8'hFF, 8'h00, 4'd0));
    vecs.push_back(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'hA5, 8'hA5, 4'd8)); // load
    vecs.push_back(mk(1, 1, 3'd1, 3'd3, 1, 0, 8'h00, 8'hF4, 4'd5)); // shr, fill 1
    vecs.push_back(mk(1, 1, 3'd2, 3'd2, 0, 0, 8'h00, 8'hD0, 4'd3)); // shl, fill 0
    vecs.push_back(mk(1, 1, 3'd1, 3'd7, 0, 0, 8'h00, 8'h01, 4'd0)); // saturate
    vecs.push_back(mk(1, 1, 3'd2, 3'd1, 0, 1, 8'h00, 8'h03, 4'd0)); // stays 0
    vecs.push_back(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'h81, 8'h81, 4'd8));
    vecs.push_back(mk(1, 1, 3'd4, 3'd1, 0, 0, 8'h00, 8'hC0, 4'd8)); // ror
    vecs.push_back(mk(1, 1, 3'd5, 3'd2, 0, 0, 8'h00, 8'h03, 4'd8)); // rol
    vecs.push_back(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'h90, 8'h90, 4'd8));
    vecs.push_back(mk(1, 1, 3'd6, 3'd2, 0, 0, 8'h00, 8'hE4, 4'd6)); // asr negative
    vecs.push_back(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'h35, 8'h35, 4'd8));
    vecs.push_back(mk(1, 1, 3'd6, 3'd3, 1, 0, 8'h00, 8'h06, 4'd5)); // asr ignores rsin
    vecs.push_back(mk(1, 1, 3'd2, 3'd3, 0, 1, 8'h00, 8'h37, 4'd2)); // shl, fill 1
    vecs.push_back(mk(1, 1, 3'd0, 3'd5, 1, 1, 8'hFF, 8'h37, 4'd2)); // hold
    vecs.push_back(mk(1, 1, 3'd4, 3'd3, 0, 0, 8'h00, 8'hE6, 4'd2)); // ror 3
    vecs.push_back(mk(1, 1, 3'd5, 3'd7, 0, 0, 8'h00, 8'h73, 4'd2)); // rol 7

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Enable low holds state across several edges, then clear.
    step(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'h3C, 8'h3C, 4'd8), 100);
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 3'd1, 3'd4, 1, 0, 8'h00, 8'h3C, 4'd8), 101 + i);
    step(mk(1, 1, 3'd7, 3'd0, 0, 0, 8'hFF, 8'h00, 4'd0), 104);

    // Zero distance, then reset in the middle of a shift sequence.
    step(mk(1, 1, 3'd3, 3'd0, 0, 0, 8'h5A, 8'h5A, 4'd8), 200);
    step(mk(1, 1, 3'd1, 3'd0, 1, 0, 8'h00, 8'h5A, 4'd8), 201);
    step(mk(0, 1, 3'd2, 3'd1, 0, 1, 8'h00, 8'h00, 4'd0), 202);
    step(mk(1, 1, 3'd1, 3'd1, 1, 0, 8'h00, 8'h80, 4'd0), 203); // acts on zeroed state

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_param.md
# univ_shift_reg_param

Parametrised universal shift register: a WIDTH-bit register with eight operating modes. Modes cover hold, logical shift left/right by a programmable distance, parallel load, rotate left/right, arithmetic shift right and clear. A bits-remaining counter reports how many originally loaded bits have not yet been shifted out. The block serves as the general serialiser/deserialiser and barrel-shift storage element for datapath blocks in this design.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- AMT_W, $clog2(WIDTH), width of the shift-distance input.
- CNT_W, $clog2(WIDTH+1), width of the bits-remaining counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- en  input  1  operation enable; 0 holds all state.
- mode  input  3  operation select (see Operation).
- amt  input  AMT_W  shift/rotate distance, 0..WIDTH-1.
- right_s_in  input  1  fill bit entering at the MSB end on a logical right shift.
- left_s_in  input  1  fill bit entering at the LSB end on a logical left shift.
- pin  input  WIDTH  parallel load data.
- pout  output  WIDTH  register contents.
- s_left  output  1  equals pout[0].
- s_right  output  1  equals pout[WIDTH-1].
- bits_left  output  CNT_W  count of loaded bits not yet shifted out.
- empty  output  1  1 when bits_left == 0.

## Operation
- Priority on each rising edge: reset, then en, then mode.
- reset == 0: pout <= 0, bits_left <= 0. This holds regardless of en and mode.
- en == 0: pout and bits_left hold.
- Modes when en == 1 (k = amt):
  - 0 hold: no change.
  - 1 logical shift right: pout <= {k copies of right_s_in, pout[WIDTH-1:k]}.
  - 2 logical shift left: pout <= {pout[WIDTH-1-k:0], k copies of left_s_in}.
  - 3 parallel load: pout <= pin; bits_left <= WIDTH.
  - 4 rotate right by k: bits wrap from LSB to MSB.
  - 5 rotate left by k: bits wrap from MSB to LSB.
  - 6 arithmetic shift right: vacated MSBs are filled with the old pout[WIDTH-1]. right_s_in is ignored.
  - 7 clear: pout <= 0; bits_left <= 0.
- bits_left update:
  - Modes 1, 2 and 6: bits_left <= bits_left - k, saturating at 0. The subtraction never wraps.
  - Modes 0, 4 and 5: bits_left unchanged.
- Distance k = 0 in any shift or rotate mode leaves pout unchanged and bits_left unchanged.
- amt values >= WIDTH are only possible when WIDTH is not a power of 2. They are treated as WIDTH-1.
- s_left, s_right and empty are combinational decodes of registered state. There is no combinational path from any input to any output.

## Timing
- Single-cycle latency. A mode applied with en == 1 before edge N is visible on pout and bits_left immediately after edge N.
- Reset values: pout = 0, s_left = 0, s_right = 0, bits_left = 0, empty = 1.
- Reset asserted mid-sequence (e.g. between two shifts) discards all state on that edge. The next non-reset edge operates on the zeroed state.
- Load and shift in consecutive cycles: the shift operates on the freshly loaded value.
- No handshake: every enabled edge performs exactly one operation.

## Test plan
All scenarios use WIDTH = 8.
- Reset: hold reset = 0 for 2 edges with en = 1, mode = 3, pin = 8'hFF -> pout = 8'h00, bits_left = 0, empty = 1. Release reset, then load 8'hA5 -> pout = 8'hA5, bits_left = 8, s_left = 1, s_right = 1.
- Shifts: from pout = 8'hA5, mode 1, amt = 3, right_s_in = 1 -> pout = 8'hF4, bits_left = 5. Then mode 2, amt = 2, left_s_in = 0 -> pout = 8'hD0, bits_left = 3.
- Saturation: from bits_left = 3, mode 1, amt = 7 -> bits_left = 0 (no wrap), empty = 1. Next, mode 2, amt = 1 -> bits_left stays 0.
- Rotate and arithmetic: load 8'h81; mode 4, amt = 1 -> pout = 8'hC0, bits_left = 8. Mode 5, amt = 2 -> pout = 8'h03. Load 8'h90; mode 6, amt = 2, right_s_in = 0 -> pout = 8'hE4.
- Enable and clear: load 8'h3C; en = 0 with mode 1, amt = 4 for 3 edges -> pout = 8'h3C, bits_left = 8. Then en = 1, mode 7 -> pout = 8'h00, empty = 1.
- amt = 0 and mid-op reset: load 8'h5A; mode 1, amt = 0 -> pout = 8'h5A, bits_left = 8. Then reset = 0 together with mode 2, amt = 1 -> pout = 8'h00, bits_left = 0.
